mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory of the multi-cycle MIPS between two requesters: port 0 is the CPU (datapath memory port) and port 1 is the DMA/program loader.
- Owns the memory-side control (read/write strobes, address, write data) and returns a one-cycle ack per transaction.
- Sits between the datapath/controller pair and the memory model. The CPU controller holds its current state until it sees the ack.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the unified MIPS memory: port 0 = CPU, port 1 = DMA/loader.
// Optional wait-cycle counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [15:0]   cpu_wait_cnt,
    output logic [15:0]   dma_wait_cnt,
`endif
    output logic          busy
);

    // state  | meaning
    // IDLE   | no transaction; arbitrate and latch the winner
    // ACCESS | memory strobed from latched request for MEM_LAT cycles
    // DONE   | one-cycle ack to the winner, strobes low
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t        state;
    state_t        state_next;
    logic          last_grant;
    logic          lat_port;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [3:0]    lat_cnt;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;
    logic          any_req;
    logic          grant_dma;
    logic          access_last;

    assign any_req     = cpu_req | dma_req;
    // On a tie the port that did not win last time takes the grant.
    assign grant_dma   = dma_req & (~cpu_req | ~last_grant);
    assign access_last = (state == ACCESS) && (lat_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_cnt == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        dma_ack   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            ACCESS: begin
                mem_read  = ~lat_we;
                mem_write = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
            end
            DONE: begin
                cpu_ack = ~lat_port;
                dma_ack = lat_port;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_cnt    <= 4'd0;
        end else if (state == IDLE && any_req) begin
            last_grant <= grant_dma;
            lat_port   <= grant_dma;
            lat_we     <= grant_dma ? dma_we    : cpu_we;
            lat_addr   <= grant_dma ? dma_addr  : cpu_addr;
            lat_wdata  <= grant_dma ? dma_wdata : cpu_wdata;
            lat_cnt    <= LAT_LOAD;
        end else if (state == ACCESS && lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
        end
    end

    // Read data is held per port until the next read on that port completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (access_last && !lat_we) begin
            if (lat_port) begin
                dma_rdata_q <= mem_rdata;
            end else begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

`ifdef MEM_ARB_PERF_EN
    logic cpu_served;
    logic dma_served;

    // A port granted in IDLE is already being serviced that cycle.
    assign cpu_served = (state == IDLE) ? (cpu_req & ~grant_dma) : ~lat_port;
    assign dma_served = (state == IDLE) ? grant_dma : lat_port;

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_wait_cnt <= 16'd0;
            dma_wait_cnt <= 16'd0;
        end else begin
            if (cpu_req && !cpu_served && cpu_wait_cnt != 16'hFFFF) begin
                cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
            end
            if (dma_req && !dma_served && dma_wait_cnt != 16'hFFFF) begin
                dma_wait_cnt <= dma_wait_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with MEM_LAT = 2.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic        cpu_ack, dma_ack, mem_read, mem_write, busy;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] cpu_wait_cnt, dma_wait_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MEM_ARB_PERF_EN
        .cpu_wait_cnt(cpu_wait_cnt), .dma_wait_cnt(dma_wait_cnt),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        mem_rdata = 0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 0);
        chk("rst_acks", {30'd0, cpu_ack, dma_ack}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        reset = 1'b0;
        tick();

        // CPU read of 0x10
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("rd_a1_busy", {31'd0, busy}, 1);
        chk("rd_a1_read", {30'd0, mem_read, mem_write}, 2'b10);
        chk("rd_a1_addr", mem_addr, 32'h10);
        chk("rd_a1_ack", {30'd0, cpu_ack, dma_ack}, 0);
        tick();
        chk("rd_a2_read", {30'd0, mem_read, mem_write}, 2'b10);
        chk("rd_a2_ack", {30'd0, cpu_ack, dma_ack}, 0);
        tick();
        chk("rd_done_ack", {30'd0, cpu_ack, dma_ack}, 2'b10);
        chk("rd_done_strobes", {30'd0, mem_read, mem_write}, 0);
        chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 0; mem_rdata = 32'h0BADF00D;
        tick();
        chk("rd_idle_busy", {31'd0, busy}, 0);
        chk("rd_idle_ack", {30'd0, cpu_ack, dma_ack}, 0);

        // DMA write of 0x12345678 to 0x40
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
        tick();
        chk("wr_a1_strobes", {30'd0, mem_read, mem_write}, 2'b01);
        chk("wr_a1_addr", mem_addr, 32'h40);
        chk("wr_a1_wdata", mem_wdata, 32'h12345678);
        tick();
        chk("wr_a2_strobes", {30'd0, mem_read, mem_write}, 2'b01);
        tick();
        chk("wr_done_ack", {30'd0, cpu_ack, dma_ack}, 2'b01);
        chk("wr_done_strobes", {30'd0, mem_read, mem_write}, 0);
        chk("wr_dma_rdata_kept", dma_rdata, 0);
        chk("wr_cpu_rdata_kept", cpu_rdata, 32'hDEADBEEF);
        dma_req = 0; dma_we = 0;
        tick();
        chk("wr_idle_busy", {31'd0, busy}, 0);

        // Contention from reset: CPU, DMA, CPU, DMA
        reset = 1;
        tick();
        reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        dma_req = 1; dma_we = 0; dma_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'h1000 + i;
            tick();
            chk($sformatf("arb%0d_addr", i), mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            tick();
            chk($sformatf("arb%0d_noack", i), {30'd0, cpu_ack, dma_ack}, 0);
            tick();
            chk($sformatf("arb%0d_ack", i), {30'd0, cpu_ack, dma_ack},
                (i % 2 == 0) ? 32'd2 : 32'd1);
            chk($sformatf("arb%0d_rdata", i), (i % 2 == 0) ? cpu_rdata : dma_rdata, 32'h1000 + i);
            if (i == 3) begin
                cpu_req = 0; dma_req = 0;
            end
            tick();
            chk($sformatf("arb%0d_gap", i), {30'd0, cpu_ack, dma_ack}, 0);
        end
        chk("arb_idle_busy", {31'd0, busy}, 0);

        // Request changes after grant are ignored
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; mem_rdata = 32'h2020;
        tick();
        chk("mid_a1_addr", mem_addr, 32'h20);
        cpu_addr = 32'h24; cpu_req = 0;
        tick();
        chk("mid_a2_addr", mem_addr, 32'h20);
        chk("mid_a2_read", {30'd0, mem_read, mem_write}, 2'b10);
        tick();
        chk("mid_ack", {30'd0, cpu_ack, dma_ack}, 2'b10);
        chk("mid_rdata", cpu_rdata, 32'h2020);
        tick();
        chk("mid_ack_once", {30'd0, cpu_ack, dma_ack}, 0);
        tick();
        chk("mid_no_restart", {31'd0, busy}, 0);

        // Reset during the second ACCESS cycle
        cpu_req = 1; cpu_addr = 32'h30; mem_rdata = 32'h3030;
        tick();
        tick();
        chk("rma_a2_read", {30'd0, mem_read, mem_write}, 2'b10);
        reset = 1;
        tick();
        chk("rma_busy", {31'd0, busy}, 0);
        chk("rma_strobes", {30'd0, mem_read, mem_write}, 0);
        chk("rma_ack", {30'd0, cpu_ack, dma_ack}, 0);
        chk("rma_rdata_clr", cpu_rdata, 0);
        reset = 0; cpu_req = 0;
        tick();
        chk("rma_no_ack", {30'd0, cpu_ack, dma_ack}, 0);
        dma_req = 1; dma_we = 0; dma_addr = 32'h50; mem_rdata = 32'hCAFEF00D;
        tick();
        chk("rma_dma_addr", mem_addr, 32'h50);
        tick();
        tick();
        chk("rma_dma_ack", {30'd0, cpu_ack, dma_ack}, 2'b01);
        chk("rma_dma_rdata", dma_rdata, 32'hCAFEF00D);
        dma_req = 0;
        tick();
        chk("end_busy", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
